counter_ir_cfg_ctrl: RTL

COUNTER_IR_CFG_CTRL -- requirements
Module: counter_ir_cfg_ctrl

---
 rtl/counter_ir_pkg.sv | 46 ++++
 rtl/counter_ir_commit_fsm.sv | 81 ++++++++
 rtl/counter_ir_cfg_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/counter_ir_pkg.sv
// Shared register map, reset values and commit-FSM state encoding for the
// IR frontend configuration controller.
package counter_ir_pkg;

  localparam logic [2:0] ADDR_VALUE_A     = 3'd0;
  localparam logic [2:0] ADDR_VALUE_B     = 3'd1;
  localparam logic [2:0] ADDR_DIN_BYPASS  = 3'd2;
  localparam logic [2:0] ADDR_DOUT_OPTS   = 3'd3;
  localparam logic [2:0] ADDR_DOUT_BYPASS = 3'd4;
  localparam logic [2:0] ADDR_STATUS      = 3'd5;

  localparam logic [31:0] RST_VALUE       = 32'd15;
  localparam logic [1:0]  RST_DIN_BYPASS  = 2'b11;
  localparam logic [7:0]  RST_DOUT_OPTS   = 8'h22;
  localparam logic [1:0]  RST_DOUT_BYPASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_QUIET = 2'd1,
    ST_APPLY      = 2'd2,
    ST_DONE       = 2'd3
  } commit_state_t;

  typedef struct packed {
    logic [31:0] value_a;
    logic [31:0] value_b;
    logic [1:0]  din_bypass;
    logic [7:0]  dout_opts;
    logic [1:0]  dout_bypass;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    value_a:     RST_VALUE,
    value_b:     RST_VALUE,
    din_bypass:  RST_DIN_BYPASS,
    dout_opts:   RST_DOUT_OPTS,
    dout_bypass: RST_DOUT_BYPASS
  };

  // Only the five configuration fields accept writes; status and the
  // reserved slots are read-only.
  function automatic logic is_writable(input logic [2:0] addr);
    return addr <= ADDR_DOUT_BYPASS;
  endfunction

endpackage

// File: rtl/counter_ir_commit_fsm.sv
// Commit sequencer: waits for a quiet cycle on both monitored pulses (or a
// timeout), then requests a single-edge shadow-to-active copy.
module counter_ir_commit_fsm
  import counter_ir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic din_a,
  input  logic din_b,
  input  logic clr_sticky,
  output logic idle,
  output logic busy,
  output logic apply,
  output logic done,
  output logic timeout_sticky
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  commit_state_t    state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             apply_reg;
  logic             done_reg;
  logic             sticky_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      apply_reg  <= 1'b0;
      done_reg   <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      apply_reg <= 1'b0;
      done_reg  <= 1'b0;
      if (clr_sticky) sticky_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (commit) begin
            state_reg <= ST_WAIT_QUIET;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_WAIT_QUIET: begin
          if (!din_a && !din_b) begin
            state_reg <= ST_APPLY;
            apply_reg <= 1'b1;
          end else if (cnt_reg == CNT_LAST) begin
            // Frontend never went quiet: force the update and flag it.
            state_reg  <= ST_APPLY;
            apply_reg  <= 1'b1;
            sticky_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_APPLY: begin
          state_reg <= ST_DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign idle           = (state_reg == ST_IDLE);
  assign busy           = busy_reg;
  assign apply          = apply_reg;
  assign done           = done_reg;
  assign timeout_sticky = sticky_reg;

endmodule

// File: rtl/counter_ir_cfg_ctrl.sv
// Shadow/active configuration register file for the IR frontend; the active
// set only changes through a commit that avoids in-flight stretched pulses.
module counter_ir_cfg_ctrl
  import counter_ir_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_wr,
  input  logic [2:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_wdata,
  input  logic        i_cfg_rd,
  output logic [31:0] o_cfg_rdata,
  input  logic        i_cfg_commit,
  output logic        o_cfg_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  input  logic        i_ir_din_a,
  input  logic        i_ir_din_b,
  output logic [31:0] o_ir_din_onecycle_value_a,
  output logic [31:0] o_ir_din_onecycle_value_b,
  output logic [1:0]  o_ir_din_bypass,
  output logic [7:0]  o_ir_dout_opts,
  output logic [1:0]  o_ir_dout_bypass
);

  cfg_t        shadow_reg;
  cfg_t        active_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  logic        err_reg;

  logic idle;
  logic busy;
  logic apply;
  logic done;
  logic timeout_sticky;
  logic wr_accept;

  assign wr_accept = i_cfg_wr && !busy && is_writable(i_cfg_addr);

  counter_ir_commit_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_commit_fsm (
    .clk            (i_clk),
    .rst_n          (i_rst_n),
    .commit         (i_cfg_commit),
    .din_a          (i_ir_din_a),
    .din_b          (i_ir_din_b),
    .clr_sticky     (wr_accept),
    .idle           (idle),
    .busy           (busy),
    .apply          (apply),
    .done           (done),
    .timeout_sticky (timeout_sticky)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_reg <= CFG_RESET;
    end else if (wr_accept) begin
      case (i_cfg_addr)
        ADDR_VALUE_A:     shadow_reg.value_a     <= i_cfg_wdata;
        ADDR_VALUE_B:     shadow_reg.value_b     <= i_cfg_wdata;
        ADDR_DIN_BYPASS:  shadow_reg.din_bypass  <= i_cfg_wdata[1:0];
        ADDR_DOUT_OPTS:   shadow_reg.dout_opts   <= i_cfg_wdata[7:0];
        ADDR_DOUT_BYPASS: shadow_reg.dout_bypass <= i_cfg_wdata[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_reg <= CFG_RESET;
    end else if (apply) begin
      active_reg <= shadow_reg;
    end
  end

  always_comb begin
    rdata_next = '0;
    case (i_cfg_addr)
      ADDR_VALUE_A:     rdata_next = shadow_reg.value_a;
      ADDR_VALUE_B:     rdata_next = shadow_reg.value_b;
      ADDR_DIN_BYPASS:  rdata_next = {30'd0, shadow_reg.din_bypass};
      ADDR_DOUT_OPTS:   rdata_next = {24'd0, shadow_reg.dout_opts};
      ADDR_DOUT_BYPASS: rdata_next = {30'd0, shadow_reg.dout_bypass};
      ADDR_STATUS:      rdata_next = {30'd0, timeout_sticky, busy};
      default:          rdata_next = '0;
    endcase
  end

  // A rejected write and a rejected commit in the same cycle share one pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (i_cfg_rd) rdata_reg <= rdata_next;
      err_reg <= (i_cfg_wr && !wr_accept) || (i_cfg_commit && !idle);
    end
  end

  assign o_cfg_rdata               = rdata_reg;
  assign o_cfg_busy                = busy;
  assign o_cfg_done                = done;
  assign o_cfg_err                 = err_reg;
  assign o_ir_din_onecycle_value_a = active_reg.value_a;
  assign o_ir_din_onecycle_value_b = active_reg.value_b;
  assign o_ir_din_bypass           = active_reg.din_bypass;
  assign o_ir_dout_opts            = active_reg.dout_opts;
  assign o_ir_dout_bypass          = active_reg.dout_bypass;

endmodule
